// File: rtl/sync_fifo_pkg.sv
// Shared constants and parameter-legality helpers for the sync_fifo family.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read mode).
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_POINTER   = 4;
  localparam int DEF_AFULL_TH  = 12;
  localparam int DEF_AEMPTY_TH = 2;

  function automatic int fifo_depth(input int pointer);
    return 1 << pointer;
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int cnt_width(input int pointer);
    return pointer + 1;
  endfunction

  function automatic bit afull_th_ok(input int th, input int pointer);
    return (th >= 1) && (th <= fifo_depth(pointer));
  endfunction

  function automatic bit aempty_th_ok(input int th, input int pointer);
    return (th >= 0) && (th <= fifo_depth(pointer) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module sync_fifo_ram #(
  parameter int WIDTH   = 8,
  parameter int POINTER = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [POINTER-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [POINTER-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [1 << POINTER];

  // NOTE: storage has no reset; pointers define validity, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int POINTER   = DEF_POINTER,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  output logic               wr_full,
  output logic               rd_empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [POINTER:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int CNT_W = cnt_width(POINTER);
  localparam int DEPTH = fifo_depth(POINTER);

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0] PTR_ONE    = CNT_W'(1);

  if (!afull_th_ok(AFULL_TH, POINTER)) begin : g_bad_afull_th
    $error("sync_fifo: AFULL_TH must lie in 1..DEPTH");
  end
  if (!aempty_th_ok(AEMPTY_TH, POINTER)) begin : g_bad_aempty_th
    $error("sync_fifo: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             pop_accept;
  logic             wr_accept;

  // Flags decode from registered pointers only, so they never glitch within a cycle.
  assign count        = wr_ptr - rd_ptr;
  assign rd_empty     = (count == '0);
  assign wr_full      = (count == DEPTH_CNT);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // A pop on a full FIFO frees the slot the write lands in during the same edge.
  assign pop_accept = rd_en && !rd_empty;
  assign wr_accept  = wr_en && (!wr_full || pop_accept);

  sync_fifo_ram #(
    .WIDTH   (WIDTH),
    .POINTER (POINTER)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[POINTER-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[POINTER-1:0]),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_accept) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= wr_en && !wr_accept;
      underflow <= rd_en && !pop_accept;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = rd_data;
  assign rd_valid = !rd_empty;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_accept;
      if (pop_accept) data_out <= rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors plus a data scoreboard.
module tb_sync_fifo;

  localparam int WIDTH     = 8;
  localparam int POINTER   = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             wr_full;
  logic             rd_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [POINTER:0] count;
  logic             overflow;
  logic             underflow;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .POINTER   (POINTER),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .wr_full      (wr_full),
    .rd_empty     (rd_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         exp_count;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_af;
    bit         exp_ae;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input bit wr, input bit rd, input logic [7:0] din, input int c);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.exp_count = c;
    v.exp_full  = (c == DEPTH);
    v.exp_empty = (c == 0);
    v.exp_af    = (c >= AFULL_TH);
    v.exp_ae    = (c <= AEMPTY_TH);
    vecs.push_back(v);
  endfunction

  // One clock of stimulus; the scoreboard decides acceptance and expected read data.
  task automatic apply(input bit wr, input bit rd, input logic [7:0] din);
    int         cnt;
    bit         pop;
    bit         push;
    logic [7:0] exp_d;
    cnt   = sb.size();
    pop   = rd && (cnt != 0);
    push  = wr && ((cnt < DEPTH) || pop);
    exp_d = 8'h00;
    if (pop)  exp_d = sb.pop_front();
    if (push) sb.push_back(din);
`ifdef SYNC_FIFO_FWFT_EN
    if (pop) begin
      check("fwft_valid_before_pop", rd_valid, 1);
      check("fwft_head_data", data_out, exp_d);
    end
`endif
    wr_en = wr; rd_en = rd; data_in = din;
    @(posedge clk); #1;
    check("overflow", overflow, wr && !push);
    check("underflow", underflow, rd && !pop);
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", rd_valid, sb.size() != 0);
`else
    check("rd_valid", rd_valid, pop);
    if (pop) check("data_out", data_out, exp_d);
`endif
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, rd_empty, 1);
    check({tag, "_full"}, wr_full, 0);
    check({tag, "_aempty"}, almost_empty, 1);
    check({tag, "_afull"}, almost_full, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_underflow"}, underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check({tag, "_data_out"}, data_out, 0);
`endif
  endtask

  initial begin
    logic [7:0] held;

    // Fill from empty, overflow, full-with-pop, drain, underflow, pop-on-empty.
    for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 8'(i), i + 1);
    add(1'b1, 1'b0, 8'hAA, 16);
    add(1'b0, 1'b0, 8'h00, 16);
    add(1'b1, 1'b1, 8'h55, 16);
    for (int i = 0; i < 16; i++) add(1'b0, 1'b1, 8'h00, 15 - i);
    add(1'b0, 1'b1, 8'h00, 0);
    add(1'b0, 1'b0, 8'h00, 0);
    add(1'b1, 1'b1, 8'h77, 1);
    add(1'b0, 1'b1, 8'h00, 0);

    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].wr, vecs[k].rd, vecs[k].din);
      check($sformatf("v%0d_count", k), count, vecs[k].exp_count);
      check($sformatf("v%0d_full", k), wr_full, vecs[k].exp_full);
      check($sformatf("v%0d_empty", k), rd_empty, vecs[k].exp_empty);
      check($sformatf("v%0d_afull", k), almost_full, vecs[k].exp_af);
      check($sformatf("v%0d_aempty", k), almost_empty, vecs[k].exp_ae);
    end

`ifndef SYNC_FIFO_FWFT_EN
    held = data_out;
    apply(1'b0, 1'b0, 8'h00);
    check("data_out_hold", data_out, 8'h77);
    check("data_out_hold_stable", data_out, held);
`endif

    // Sustained write+pop at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 8'(8'h80 + i));
    check("stream_start_count", count, 5);
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 1'b1, 8'(8'hA0 + i));
      check("stream_count", count, 5);
    end
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 8'h00);
    check("stream_drained", rd_empty, 1);

    // Write latency: FWFT shows the word right after the write edge.
    apply(1'b1, 1'b0, 8'h5A);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_latency_valid", rd_valid, 1);
    check("fwft_latency_data", data_out, 8'h5A);
`else
    check("std_no_valid_before_pop", rd_valid, 0);
`endif
    apply(1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-stream at count 7.
    for (int i = 0; i < 7; i++) apply(1'b1, 1'b0, 8'(8'hC0 + i));
    check("pre_reset_count", count, 7);
    idle_inputs();
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    check_reset_outputs("held_rst");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    apply(1'b1, 1'b0, 8'h3C);
    check("post_reset_count", count, 1);
    apply(1'b0, 1'b1, 8'h00);
    check("post_reset_empty", rd_empty, 1);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
